adc_capture_buffer: RTL and testbench

Triggered sample-capture buffer between the 8-bit parallel ADC input and the SPI slave readout. Samples `adc_d` with programmable decimation and waits for a level-crossing trigger. It then records `2**DEPTH_LOG2` consecutive samples into on-chip RAM and presents them one byte at a time for the SPI slave to shift out. Single clock domain, driven by the ADC sample clock.

---
 rtl/adc_cap_pkg.sv | 13 +
 rtl/adc_capture_buffer_sample_ram.sv | 28 ++
 rtl/adc_capture_buffer.sv | 153 +++++++++++++++
 tb/tb_adc_capture_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared constants for the ADC capture buffer: sample width, default depth
// and the FSM state encodings that also drive the status/debug output.
package adc_cap_pkg;

    localparam int SAMPLE_W       = 8;
    localparam int DEPTH_LOG2_DEF = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/adc_capture_buffer_sample_ram.sv
// Capture storage: one write port, one registered read port, no reset so it
// maps onto a block RAM.
module sample_ram
    import adc_cap_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [SAMPLE_W-1:0]   wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [SAMPLE_W-1:0]   rdata
);

    logic [SAMPLE_W-1:0] mem [2**DEPTH_LOG2];
    logic [SAMPLE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered ADC capture: decimated sampling, level-crossing trigger, fills
// sample_ram once, then serves it a byte at a time to the SPI readout.
//
// state   | meaning
// IDLE    | inert after reset, waits for arm
// ARMED   | watching strobed samples for a trigger
// CAPTURE | writing one sample per strobe until the buffer is full
// DONE    | buffer frozen, readout active until the next arm
module adc_capture_buffer
    import adc_cap_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int DECIM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] adc_d,
    input  logic                arm,
    input  logic                force_trig,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_rising,
    input  logic [DECIM_W-1:0]  decim,
    input  logic                rd_next,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic [1:0]          state
);

    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

    logic [SAMPLE_W-1:0]   s_reg_q, s_reg_d;
    logic [SAMPLE_W-1:0]   prev_q, prev_d;
    logic                  prev_ok_q, prev_ok_d;
    logic [DECIM_W-1:0]    dcnt_q, dcnt_d;
    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    // Extra MSB marks "every address consumed" so rd_valid can fall cleanly.
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  strobe;
    logic                  crossing;
    logic                  trigger;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [SAMPLE_W-1:0]   ram_rdata;

    always_comb begin
        strobe   = (dcnt_q == '0);
        crossing = trig_rising ? ((prev_q <  trig_level) && (s_reg_q >= trig_level))
                               : ((prev_q >= trig_level) && (s_reg_q <  trig_level));
        trigger  = strobe && (force_trig || (prev_ok_q && crossing));

        s_reg_d    = adc_d;
        prev_d     = prev_q;
        prev_ok_d  = prev_ok_q;
        dcnt_d     = dcnt_q;
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        ram_we     = 1'b0;
        ram_waddr  = wr_ptr_q;

        if (arm) begin
            dcnt_d     = '0;
            prev_ok_d  = 1'b0;
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_valid_d = 1'b0;
        end else begin
            dcnt_d = (dcnt_q >= decim) ? '0 : dcnt_q + 1'b1;
            if (strobe) begin
                prev_d    = s_reg_q;
                prev_ok_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    if (trigger) begin
                        ram_we    = 1'b1;
                        ram_waddr = '0;
                        wr_ptr_d  = DEPTH_LOG2'(1);
                        state_d   = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (strobe) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == LAST_ADDR) begin
                            state_d  = ST_DONE;
                            rd_ptr_d = '0;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_next && rd_valid_q) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            endcase

            // Uses the current state so rd_valid trails done by one clock.
            rd_valid_d = (state_q == ST_DONE) && !rd_ptr_d[DEPTH_LOG2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_reg_q    <= '0;
            prev_q     <= '0;
            prev_ok_q  <= 1'b0;
            dcnt_q     <= '0;
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            s_reg_q    <= s_reg_d;
            prev_q     <= prev_d;
            prev_ok_q  <= prev_ok_d;
            dcnt_q     <= dcnt_d;
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Read address follows the next pointer, so the byte is ready one clock
    // after the consuming rd_next and back-to-back reads never repeat a byte.
    sample_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (s_reg_q),
        .raddr (rd_ptr_d[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    assign rd_data  = rd_valid_q ? ram_rdata : '0;
    assign rd_valid = rd_valid_q;
    assign done     = (state_q == ST_DONE);
    assign state    = state_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer: a table of trigger/decimation cases,
// each captured and fully read out, plus abort, arm/rd_next and reset sequences.
module tb_adc_capture_buffer;
    import adc_cap_pkg::*;

    localparam int N = 256;

    typedef struct {
        int         decim;
        logic [7:0] level;
        bit         rising;
        bit         force_t;
        logic [7:0] v0;       // value for k < hold
        int         hold;
        logic [7:0] v1;       // then v1 + inc*(k-hold)
        int         inc;
        int         exp_trig; // edges after the arm edge until CAPTURE
        logic [7:0] exp_first;
        int         exp_delta;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] adc_d = 8'h00;
    logic       arm = 1'b0;
    logic       force_trig = 1'b0;
    logic [7:0] trig_level = 8'h00;
    logic       trig_rising = 1'b1;
    logic [7:0] decim = 8'h00;
    logic       rd_next = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic [1:0] state;

    int   tests = 0;
    int   fails = 0;
    vec_t cur;
    int   kidx = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    adc_capture_buffer dut (
        .clk         (clk),
        .rst         (rst_n),
        .adc_d       (adc_d),
        .arm         (arm),
        .force_trig  (force_trig),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .decim       (decim),
        .rd_next     (rd_next),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .state       (state)
    );

    function automatic logic [7:0] pat(int k);
        if (k < cur.hold) return cur.v0;
        return 8'(int'(cur.v1) + cur.inc * (k - cur.hold));
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: through the rising edge to the next falling edge, where the
    // next pattern sample is driven and outputs are stable for checking.
    task automatic clk_step();
        @(posedge clk);
        @(negedge clk);
        adc_d = pat(kidx);
        kidx++;
    endtask

    task automatic start_pattern(vec_t v);
        cur   = v;
        kidx  = 0;
        adc_d = pat(kidx);
        kidx++;
    endtask

    task automatic run_capture(vec_t v, int n_read);
        int n;
        int cnt;
        logic [7:0] exp;
        decim       = 8'(v.decim);
        trig_level  = v.level;
        trig_rising = v.rising;
        force_trig  = v.force_t;
        start_pattern(v);
        arm = 1'b1;
        clk_step();
        arm = 1'b0;
        chk("armed_state", state, ST_ARMED);
        n = 0;
        do begin
            clk_step();
            n++;
        end while (state != ST_CAPTURE && n < 400);
        chk("trig_edge", n, v.exp_trig);
        force_trig = 1'b0;
        cnt = 0;
        while (state == ST_CAPTURE && cnt < 2000) begin
            clk_step();
            cnt++;
        end
        chk("cap_len", cnt, (N - 1) * (v.decim + 1));
        chk("done_state", {done, state}, {1'b1, ST_DONE});
        chk("valid_lags_done", rd_valid, 0);
        clk_step();
        for (int i = 0; i < n_read; i++) begin
            exp = 8'(int'(v.exp_first) + v.exp_delta * i);
            chk("rd_byte", {rd_valid, rd_data}, {1'b1, exp});
            rd_next = 1'b1;
            clk_step();
        end
        rd_next = 1'b0;
        if (n_read == N) begin
            chk("rd_end", {rd_valid, rd_data}, 0);
            rd_next = 1'b1;
            clk_step();
            rd_next = 1'b0;
            chk("rd_past_end", {done, state, rd_valid, rd_data}, {1'b1, ST_DONE, 1'b0, 8'h00});
        end
    endtask

    initial begin
        int   bad;
        vec_t cv;

        //          decim level  ris frc  v0    hold v1     inc trig first  delta
        vecs[0] = '{0,    8'h80, 1, 0, 8'h00, 0,  8'h70, 1,  17, 8'h80, 1};
        vecs[1] = '{3,    8'h80, 1, 0, 8'h00, 0,  8'h70, 1,  17, 8'h80, 4};
        vecs[2] = '{0,    8'h40, 0, 0, 8'h50, 10, 8'h30, 0,  11, 8'h30, 0};
        vecs[3] = '{0,    8'h80, 1, 1, 8'h00, 0,  8'h5A, 0,  1,  8'h5A, 0};
        vecs[4] = '{2,    8'h80, 1, 1, 8'h00, 0,  8'h10, 1,  1,  8'h10, 3};
        vecs[5] = '{0,    8'hFF, 0, 0, 8'hFF, 5,  8'hFE, 0,  6,  8'hFE, 0};
        cv      = '{0,    8'h80, 1, 0, 8'h33, 0,  8'h33, 0,  0,  8'h00, 0};
        cur = cv;

        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {rd_data, rd_valid, done, state}, 0);

        // Reset then idle: ramp with no arm never leaves IDLE.
        @(negedge clk);
        rst_n = 1'b1;
        start_pattern('{0, 8'h80, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0});
        bad = 0;
        for (int i = 0; i < N; i++) begin
            clk_step();
            if (state != ST_IDLE || done || rd_valid || rd_data != 8'h00) bad++;
        end
        chk("idle_no_arm", bad, 0);

        foreach (vecs[i]) run_capture(vecs[i], N);

        // Abort mid-capture with arm: back to ARMED, no done, no new trigger.
        run_capture(vecs[0], 3);
        decim = 8'h00;
        force_trig = 1'b1;
        start_pattern(cv);
        arm = 1'b1;
        clk_step();
        arm = 1'b0;
        clk_step();
        chk("abort_in_capture", state, ST_CAPTURE);
        for (int i = 0; i < 50; i++) clk_step();
        arm = 1'b1;
        force_trig = 1'b0;
        clk_step();
        arm = 1'b0;
        chk("abort_state", {done, rd_valid, state}, {1'b0, 1'b0, ST_ARMED});
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            clk_step();
            if (state != ST_ARMED || done) bad++;
        end
        chk("abort_stays_armed", bad, 0);
        run_capture(vecs[0], N);

        // arm together with rd_next in DONE: arm wins.
        run_capture(vecs[3], 5);
        arm = 1'b1;
        rd_next = 1'b1;
        clk_step();
        arm = 1'b0;
        rd_next = 1'b0;
        chk("arm_rdnext", {done, rd_valid, rd_data, state}, {1'b0, 1'b0, 8'h00, ST_ARMED});

        // Async reset between edges during readout.
        run_capture(vecs[4], 10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {rd_data, rd_valid, done, state}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clk_step();
        chk("post_reset_idle", state, ST_IDLE);
        run_capture(vecs[1], N);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
